// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_fsm
//  Description : Main control unit of the multicycle RV32I core. A Moore FSM
//                steps each instruction through fetch / decode / execute /
//                writeback and drives the datapath strobes and muxes. It also
//                waits on the unified memory handshake with a bounded timeout.
//  Ports       : clk, rst_n (async, active-low)
//                op, funct3, funct7b5  - IR fields (op latched, not valid in FETCH)
//                zero                  - ALU zero flag
//                mem_ready             - memory completes the access this cycle
//                pc_write, adr_src, mem_write, ir_write, reg_write - strobes/muxes
//                result_src, alu_src_a, alu_src_b, alu_control     - datapath muxes
//                imm_src               - immediate format, from op
//                instr_done, illegal, mem_err - one-cycle status pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       reg_write,
    output logic [2:0] imm_src,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11
    } state_t;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    // Wait counter only needs to reach MEM_TIMEOUT-1.
    localparam int             c_CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit             c_TMO_EN   = (MEM_TIMEOUT > 0);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_TMO_EN ? c_CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t             r_state;
    state_t             w_next;
    logic [c_CNT_W-1:0] r_cnt;

    logic       w_wait_state;
    logic       w_timeout;
    logic [2:0] w_funct_alu;
    logic       w_pc_write;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_instr_done;
    logic       w_illegal;
    logic       w_mem_err;

    // ------------------------------------------------------------------
    // State and wait-counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // Every exit from a wait state happens on mem_ready or a timeout,
            // so clearing here also gives a zero count on the next entry.
            if (c_TMO_EN && w_wait_state && !mem_ready && !w_timeout) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Timeout detection and ALU function decode
    // ------------------------------------------------------------------
    always_comb begin
        w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                       (r_state == S_MEMWRITE);
        // A mem_ready arriving on the final count still completes the access.
        w_timeout    = c_TMO_EN && w_wait_state && !mem_ready && (r_cnt == c_CNT_LAST);
    end

    always_comb begin
        w_funct_alu = c_ALU_ADD;
        case (funct3)
            3'b000:  w_funct_alu = (op[5] && funct7b5) ? c_ALU_SUB : c_ALU_ADD;
            3'b010:  w_funct_alu = c_ALU_SLT;
            3'b110:  w_funct_alu = c_ALU_OR;
            3'b111:  w_funct_alu = c_ALU_AND;
            default: w_funct_alu = c_ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next       = r_state;
        w_pc_write   = 1'b0;
        adr_src      = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_control  = c_ALU_ADD;
        w_reg_write  = 1'b0;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;
        w_mem_err    = 1'b0;

        case (r_state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_mem_err = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    c_OP_LOAD, c_OP_STORE: w_next = S_MEMADR;
                    c_OP_R:                w_next = S_EXEC_R;
                    c_OP_I:                w_next = S_EXEC_I;
                    c_OP_JAL:              w_next = S_JAL;
                    c_OP_LUI:              w_next = S_LUI;
                    c_OP_BR: begin
                        if (funct3 == 3'b000) begin
                            w_next = S_BEQ;
                        end else begin
                            w_illegal = 1'b1;
                            w_next    = S_FETCH;
                        end
                    end
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end else if (w_timeout) begin
                    w_mem_err = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_MEMWB: begin
                result_src   = 2'b01;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                // The write request is withdrawn on the timeout cycle.
                w_mem_write = !w_timeout;
                if (mem_ready) begin
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end else if (w_timeout) begin
                    w_mem_err = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b00;
                alu_control = w_funct_alu;
                w_next      = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = w_funct_alu;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a    = 2'b10;
                alu_control  = c_ALU_SUB;
                w_pc_write   = zero;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_JAL: begin
                // ALUOut holds the target computed in DECODE; ALU forms PC+4 for rd.
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                w_next    = S_ALUWB;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // FETCH strobes follow mem_ready combinationally, so all strobes and
    // pulses are qualified by rst_n to stay quiet while reset is held.
    assign pc_write   = rst_n & w_pc_write;
    assign mem_write  = rst_n & w_mem_write;
    assign ir_write   = rst_n & w_ir_write;
    assign reg_write  = rst_n & w_reg_write;
    assign instr_done = rst_n & w_instr_done;
    assign illegal    = rst_n & w_illegal;
    assign mem_err    = rst_n & w_mem_err;

    // Immediate format straight from the latched opcode.
    always_comb begin
        imm_src = 3'b000;
        case (op)
            c_OP_STORE: imm_src = 3'b001;
            c_OP_BR:    imm_src = 3'b010;
            c_OP_LUI:   imm_src = 3'b011;
            c_OP_JAL:   imm_src = 3'b100;
            default:    imm_src = 3'b000;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_fsm
//  Description : Scoreboard bench for multicycle_control_fsm. Directed
//                instructions push a hand-computed per-instruction summary;
//                a monitor accumulates what the DUT does and compares it on
//                every instr_done / illegal / mem_err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

    localparam int TMO = 4;

    localparam logic [2:0] K_DONE = 3'b100;
    localparam logic [2:0] K_ILL  = 3'b010;
    localparam logic [2:0] K_ERR  = 3'b001;
    localparam logic [2:0] NOALU  = 3'b111;  // instruction shorter than 3 cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control, imm_src;
    logic       instr_done, illegal, mem_err;

    multicycle_control_fsm #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .reg_write(reg_write), .imm_src(imm_src), .instr_done(instr_done),
        .illegal(illegal), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ncyc;
        logic [2:0] kind;
        int         regw, pcw, memw, irw;
        logic [2:0] alu3, imm;
        logic [1:0] rsrc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: per-instruction accumulation, compared on each pulse
    // ------------------------------------------------------------------
    int         a_cyc, a_regw, a_pcw, a_memw, a_irw;
    logic [2:0] a_alu3, a_imm;
    logic [1:0] a_rsrc;

    task automatic acc_clear();
        a_cyc = 0; a_regw = 0; a_pcw = 0; a_memw = 0; a_irw = 0;
        a_alu3 = NOALU; a_imm = 3'b000; a_rsrc = 2'b00;
    endtask

    initial acc_clear();

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_clear();
        end else begin
            a_cyc++;
            if (reg_write) begin a_regw++; a_rsrc = result_src; end
            if (pc_write)  a_pcw++;
            if (mem_write) a_memw++;
            if (ir_write)  a_irw++;
            if (a_cyc == 2) a_imm  = imm_src;
            if (a_cyc == 3) a_alu3 = alu_control;
            if (instr_done || illegal || mem_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_kind", {instr_done, illegal, mem_err}, e.kind);
                    chk("cycles", a_cyc, e.ncyc);
                    chk("reg_write_cnt", a_regw, e.regw);
                    chk("pc_write_cnt", a_pcw, e.pcw);
                    chk("mem_write_cnt", a_memw, e.memw);
                    chk("ir_write_cnt", a_irw, e.irw);
                    chk("alu_ctrl_cyc3", a_alu3, e.alu3);
                    chk("imm_src", a_imm, e.imm);
                    chk("result_src_wb", a_rsrc, e.rsrc);
                end
                acc_clear();
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: one instruction, mem_ready scheduled from the expected plan.
    // fw/mw = cycles mem_ready stays low in FETCH / the memory state.
    // ------------------------------------------------------------------
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int fw, input int mw, input bit memcls,
                       input int ncyc, input logic [2:0] kind, input int regw,
                       input int pcw, input int memw, input int irw,
                       input logic [2:0] alu3, input logic [2:0] imm,
                       input logic [1:0] rsrc);
        exp_t e;
        e.ncyc = ncyc; e.kind = kind; e.regw = regw; e.pcw = pcw; e.memw = memw;
        e.irw = irw; e.alu3 = alu3; e.imm = imm; e.rsrc = rsrc;
        exp_q.push_back(e);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        for (int i = 0; i < ncyc; i++) begin
            mem_ready = ((i == fw) && (fw < TMO)) ||
                        (memcls && (i == fw + 3 + mw) && (mw < TMO));
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        // Reset held with mem_ready high: FETCH strobes must still stay low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", {pc_write, mem_write, ir_write, reg_write,
                            instr_done, illegal, mem_err}, 0);
        chk("rst_result_src", result_src, 2);
        chk("rst_alu_src_b", alu_src_b, 2);
        chk("rst_adr_src", adr_src, 0);
        rst_n = 1'b1;

        //   op          f3     f7 z  fw mw mc n  kind   rw pw mw iw alu3    imm     rsrc
        run(7'b0110011, 3'b000, 0, 0, 0, 0, 0, 4, K_DONE, 1, 1, 0, 1, 3'b000, 3'b000, 2'b00); // add
        run(7'b0110011, 3'b000, 1, 0, 0, 0, 0, 4, K_DONE, 1, 1, 0, 1, 3'b001, 3'b000, 2'b00); // sub
        run(7'b0010011, 3'b000, 1, 0, 0, 0, 0, 4, K_DONE, 1, 1, 0, 1, 3'b000, 3'b000, 2'b00); // addi, f7b5 ignored
        run(7'b0110011, 3'b010, 0, 0, 0, 0, 0, 4, K_DONE, 1, 1, 0, 1, 3'b101, 3'b000, 2'b00); // slt
        run(7'b0010011, 3'b110, 0, 0, 0, 0, 0, 4, K_DONE, 1, 1, 0, 1, 3'b011, 3'b000, 2'b00); // ori
        run(7'b0110011, 3'b111, 0, 0, 0, 0, 0, 4, K_DONE, 1, 1, 0, 1, 3'b010, 3'b000, 2'b00); // and
        run(7'b0110011, 3'b001, 0, 0, 0, 0, 0, 4, K_DONE, 1, 1, 0, 1, 3'b000, 3'b000, 2'b00); // other f3 -> add
        // lw, ready arrives on the 4th MEMREAD cycle (same cycle as timeout would)
        run(7'b0000011, 3'b010, 0, 0, 0, 3, 1, 8, K_DONE, 1, 1, 0, 1, 3'b000, 3'b000, 2'b01);
        run(7'b0100011, 3'b010, 0, 0, 0, 2, 1, 6, K_DONE, 0, 1, 3, 1, 3'b000, 3'b001, 2'b00); // sw
        run(7'b1100011, 3'b000, 0, 1, 0, 0, 0, 3, K_DONE, 0, 2, 0, 1, 3'b001, 3'b010, 2'b00); // beq taken
        run(7'b1100011, 3'b000, 0, 0, 0, 0, 0, 3, K_DONE, 0, 1, 0, 1, 3'b001, 3'b010, 2'b00); // beq not taken
        run(7'b1111111, 3'b000, 0, 0, 0, 0, 0, 2, K_ILL,  0, 1, 0, 1, NOALU,  3'b000, 2'b00); // bad opcode
        run(7'b1100011, 3'b001, 0, 0, 0, 0, 0, 2, K_ILL,  0, 1, 0, 1, NOALU,  3'b010, 2'b00); // bne unsupported
        run(7'b1101111, 3'b000, 0, 0, 0, 0, 0, 4, K_DONE, 1, 2, 0, 1, 3'b000, 3'b100, 2'b00); // jal
        run(7'b0110111, 3'b000, 0, 0, 0, 0, 0, 4, K_DONE, 1, 1, 0, 1, 3'b000, 3'b011, 2'b00); // lui
        run(7'b0110011, 3'b000, 0, 0, 3, 0, 0, 7, K_DONE, 1, 1, 0, 1, 3'b000, 3'b000, 2'b00); // fetch late ready
        run(7'b0110011, 3'b000, 0, 0, 4, 0, 0, 4, K_ERR,  0, 0, 0, 0, 3'b000, 3'b000, 2'b00); // fetch timeout
        run(7'b0000011, 3'b010, 0, 0, 0, 4, 1, 7, K_ERR,  0, 1, 0, 1, 3'b000, 3'b000, 2'b00); // load timeout
        run(7'b0100011, 3'b010, 0, 0, 0, 4, 1, 7, K_ERR,  0, 1, 3, 1, 3'b000, 3'b001, 2'b00); // store timeout
        run(7'b0110011, 3'b000, 0, 0, 0, 0, 0, 4, K_DONE, 1, 1, 0, 1, 3'b000, 3'b000, 2'b00); // after timeouts

        // Asynchronous reset in the middle of a store.
        op = 7'b0100011; funct3 = 3'b010;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("sw_mem_write_before_rst", mem_write, 1);
        rst_n = 1'b0;
        #1;
        chk("sw_mem_write_async_rst", mem_write, 0);
        mem_ready = 1'b1;
        #1;
        chk("rst_mid_strobes", {pc_write, ir_write, reg_write, instr_done, illegal, mem_err}, 0);
        chk("rst_mid_adr_src", adr_src, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(7'b0110011, 3'b111, 0, 0, 0, 0, 0, 4, K_DONE, 1, 1, 0, 1, 3'b010, 3'b000, 2'b00); // from FETCH

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
